// File: rtl/fifo_serial_reader.sv
// fifo_serial_reader: pops one word at a time from an upstream FIFO and
// serialises it MSB first over a valid/ready bit stream.
// The controller steps through IDLE -> POP -> LOAD -> SHIFT. Each pop
// transfers exactly one word.
module fifo_serial_reader #(
    parameter int WIDTH = 16,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             empty,
    input  logic [WIDTH-1:0] rd_data,
    output logic             rd_en,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             word_done,
    output logic             busy,
    output logic [7:0]       word_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       word_cnt_q, word_cnt_d;
    logic             last_accept;

    // The final bit of a word is accepted on this cycle.
    assign last_accept = (state_q == SHIFT) && ser_ready && (cnt_q == '0);

    // Next-state, shift-register, bit-counter and word-counter updates.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        word_cnt_d = word_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (en && !empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                // The pop is committed; en and empty are not looked at here.
                state_d = LOAD;
            end
            LOAD: begin
                // The FIFO presents the popped word during this cycle.
                shift_d = rd_data;
                cnt_d   = CW'(WIDTH - 1);
                state_d = SHIFT;
            end
            SHIFT: begin
                if (ser_ready) begin
                    if (cnt_q == '0) begin
                        word_cnt_d = word_cnt_q + 8'd1;
                        state_d    = IDLE;
                    end else begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q - CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Outputs decoded from state; ser_out is forced low outside SHIFT because
    // the shift register still holds the last bit after a word.
    // word_done also needs ser_ready so that it pulses only on acceptance.
    assign rd_en     = (state_q == POP);
    assign ser_valid = (state_q == SHIFT);
    assign busy      = (state_q != IDLE);
    assign ser_out   = (state_q == SHIFT) && shift_q[WIDTH-1];
    assign word_done = last_accept;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_fifo_serial_reader.sv
// Directed bench for fifo_serial_reader. A FIFO responder supplies the
// queued words and pushes their expected bits into a scoreboard. A monitor
// pops and compares each accepted bit.
module tb_fifo_serial_reader;

    localparam int WIDTH = 16;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             empty;
    logic [WIDTH-1:0] rd_data;
    logic             rd_en;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             word_done;
    logic             busy;
    logic [7:0]       word_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [WIDTH-1:0] word_q[$];   // words the FIFO will hand out, in order
    logic [1:0]       exp_q[$];    // {last_bit_of_word, bit_value}
    int               rd_cyc[$];   // cycle numbers of rd_en pulses
    int               done_cyc[$]; // cycle numbers of word_done pulses

    fifo_serial_reader #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .empty     (empty),
        .rd_data   (rd_data),
        .rd_en     (rd_en),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .word_done (word_done),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO responder and bit monitor, both sampling mid-cycle.
    always @(negedge clk) begin
        logic [WIDTH-1:0] w;
        logic [1:0]       e;
        if (!rst) begin
            if (rd_en) begin
                rd_cyc.push_back(cyc);
                chk("pop_has_word", 32'(word_q.size() > 0), 1);
                if (word_q.size() > 0) begin
                    w = word_q.pop_front();
                    rd_data = w;
                    for (int i = WIDTH - 1; i >= 0; i--)
                        exp_q.push_back({(i == 0), w[i]});
                end
            end
            if (ser_valid && ser_ready) begin
                chk("bit_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("ser_out", ser_out, e[0]);
                    chk("word_done_last", word_done, e[1]);
                end
            end else begin
                chk("word_done_idle", word_done, 0);
            end
            if (!ser_valid) chk("ser_out_low", ser_out, 0);
            if (word_done) done_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int lim, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!word_done && n < lim);
        chk(tag, word_done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nrd;
        rst = 1'b1; en = 1'b0; empty = 1'b1; ser_ready = 1'b1; rd_data = '0;
        tick(3);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_ser_out", ser_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_word_cnt", word_cnt, 0);
        rst = 1'b0;
        tick(2);

        // Single word A5C3
        word_q.push_back(16'hA5C3);
        en = 1'b1; empty = 1'b0;
        tick(1);
        chk("w1_rd_en", rd_en, 1);
        chk("w1_busy", busy, 1);
        empty = 1'b1;
        tick(1);
        chk("w1_load_rd_en", rd_en, 0);
        chk("w1_load_valid", ser_valid, 0);
        tick(1);
        chk("w1_first_valid", ser_valid, 1);
        wait_done(40, "w1_done");
        chk("w1_latency", done_cyc[$] - rd_cyc[$], 17);
        chk("w1_word_cnt", word_cnt, 1);
        chk("w1_idle_busy", busy, 0);
        chk("w1_pops", rd_cyc.size(), 1);

        // Stall on the third bit for five cycles
        word_q.push_back(16'hA5C3);
        empty = 1'b0;
        tick(1);
        empty = 1'b1;
        tick(4);
        ser_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_bit3", ser_out, 1);
            chk("stall_valid", ser_valid, 1);
            tick(1);
        end
        chk("stall_bit3_last", ser_out, 1);
        ser_ready = 1'b1;
        wait_done(40, "stall_done");
        chk("stall_latency", done_cyc[$] - rd_cyc[$], 22);
        chk("stall_word_cnt", word_cnt, 2);

        // Back-to-back FFFF then 0001
        word_q.push_back(16'hFFFF);
        word_q.push_back(16'h0001);
        empty = 1'b0;
        wait_done(40, "b2b_done1");
        tick(1);
        chk("b2b_rd_en2", rd_en, 1);
        empty = 1'b1;
        wait_done(40, "b2b_done2");
        chk("b2b_period", rd_cyc[$] - rd_cyc[rd_cyc.size() - 2], 19);
        chk("b2b_word_cnt", word_cnt, 4);

        // Gating: en low keeps the reader idle
        en = 1'b0; empty = 1'b0;
        nrd = rd_cyc.size();
        for (int i = 0; i < 10; i++) begin
            chk("gate_rd_en", rd_en, 0);
            chk("gate_busy", busy, 0);
            tick(1);
        end
        chk("gate_pops", rd_cyc.size(), nrd);

        // en dropped mid-SHIFT: word completes, nothing further
        word_q.push_back(16'h3C96);
        en = 1'b1;
        tick(1);
        chk("drop_rd_en", rd_en, 1);
        tick(4);
        en = 1'b0;
        wait_done(40, "drop_done");
        tick(5);
        chk("drop_pops", rd_cyc.size(), nrd + 1);
        chk("drop_busy", busy, 0);
        chk("drop_word_cnt", word_cnt, 5);

        // Reset after the seventh bit
        word_q.push_back(16'hF0F0);
        en = 1'b1;
        tick(1);
        tick(2);
        tick(7);
        chk("mid_valid_pre", ser_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", ser_valid, 0);
        chk("mid_rst_out", ser_out, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_done", word_done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", word_cnt, 0);
        exp_q.delete();
        tick(2);
        nrd = rd_cyc.size();
        word_q.push_back(16'h1234);
        rst = 1'b0;
        tick(1);
        chk("post_rst_rd_en", rd_en, 1);
        empty = 1'b1;
        wait_done(40, "post_rst_done");
        chk("post_rst_pops", rd_cyc.size(), nrd + 1);
        chk("post_rst_cnt", word_cnt, 1);

        // Wrap: 256 words from a fresh reset
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 256; i++)
            word_q.push_back(WIDTH'($urandom_range(0, 65535)));
        en = 1'b1; empty = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            wait_done(40, "wrap_done");
            if (i == 255) begin
                chk("wrap_cnt_255", word_cnt, 255);
                tick(1);
                empty = 1'b1;
            end
        end
        chk("wrap_cnt_0", word_cnt, 0);
        tick(3);
        chk("wrap_idle", busy, 0);
        chk("sb_bits_left", exp_q.size(), 0);
        chk("sb_words_left", word_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
